// File: rtl/jk_counter_pkg.sv
// jk_counter_pkg
// Shared definitions for the JK-cell counter slice:
//   jk_cmd_e  - JK command encoding (hold / clear / set / toggle)
//   Q_RST     - reset value of every count bit
//   jk_next() - next Q of a single JK cell given Q, J and K
package jk_counter_pkg;

    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_CLR  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_cmd_e;

    localparam logic Q_RST = 1'b0;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic r;
        unique case (jk_cmd_e'({j, k}))
            JK_HOLD: r = q;
            JK_CLR:  r = 1'b0;
            JK_SET:  r = 1'b1;
            JK_TGL:  r = ~q;
            default: r = q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// jk_cell
// Single-bit JK flip-flop with synchronous active-high reset.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset (q -> Q_RST)
//   j,k - JK command inputs (00 hold, 01 clear, 10 set, 11 toggle)
//   q   - registered state
//   qn  - complement of q
module jk_cell
    import jk_counter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qn
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= Q_RST;
        end else begin
            q <= jk_next(q, j, k);
        end
    end

    assign qn = ~q;

endmodule

// File: rtl/jk_sync_counter.sv
// jk_sync_counter
// Synchronous modulo-MOD up/down counter built from WIDTH jk_cell instances.
// Each cell is driven with J/K derived from the desired next count so that
// set/clear commands move it there; cells hold when not enabled.
// Optional feature macro: JKCNT_LOAD_EN (adds input_load / input_din).
// The count sequence runs 0..MOD-1 over a WIDTH-bit register.
// Ports:
//   input_clk      - rising-edge clock
//   input_rst      - synchronous active-high reset
//   input_en       - count enable
//   input_up       - 1 = count up, 0 = count down
//   input_clr_flag - clears the sticky wrap flag
//   input_load     - parallel load strobe (JKCNT_LOAD_EN only)
//   input_din      - parallel load value (JKCNT_LOAD_EN only)
//   output_q       - count value
//   output_qn      - complement of output_q
//   output_tc      - combinational terminal count (cascade enable)
//   output_wrap    - registered sticky wrap flag
module jk_sync_counter
    import jk_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic             input_clk,
    input  logic             input_rst,
    input  logic             input_en,
    input  logic             input_up,
    input  logic             input_clr_flag,
`ifdef JKCNT_LOAD_EN
    input  logic             input_load,
    input  logic [WIDTH-1:0] input_din,
`endif
    output logic [WIDTH-1:0] output_q,
    output logic [WIDTH-1:0] output_qn,
    output logic             output_tc,
    output logic             output_wrap
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;

    // Out-of-range counts (only reachable from a glitched state) fall back
    // into the legal sequence in either direction.
    always_comb begin
        nxt = output_q;
        if (input_up) begin
            nxt = (output_q >= MAX_Q) ? '0 : output_q + WIDTH'(1);
        end else begin
            nxt = (output_q == '0 || output_q > MAX_Q) ? MAX_Q : output_q - WIDTH'(1);
        end
    end

`ifdef JKCNT_LOAD_EN
    logic [WIDTH-1:0] load_val;
    assign load_val = (input_din > MAX_Q) ? '0 : input_din;

    // Load drives every cell with set/clear toward load_val, overriding count.
    always_comb begin
        j = '0;
        k = '0;
        if (input_load) begin
            j = load_val;
            k = ~load_val;
        end else begin
            j = {WIDTH{input_en}} & ~output_q &  nxt;
            k = {WIDTH{input_en}} &  output_q & ~nxt;
        end
    end
`else
    always_comb begin
        j = {WIDTH{input_en}} & ~output_q &  nxt;
        k = {WIDTH{input_en}} &  output_q & ~nxt;
    end
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk (input_clk),
            .rst (input_rst),
            .j   (j[i]),
            .k   (k[i]),
            .q   (output_q[i]),
            .qn  (output_qn[i])
        );
    end

    assign output_tc = input_en & (input_up ? (output_q == MAX_Q) : (output_q == '0));

    // Set beats clear; a load cycle leaves the flag untouched.
    always_ff @(posedge input_clk) begin
        if (input_rst) begin
            output_wrap <= 1'b0;
`ifdef JKCNT_LOAD_EN
        end else if (input_load) begin
            output_wrap <= output_wrap;
`endif
        end else if (output_tc) begin
            output_wrap <= 1'b1;
        end else if (input_clr_flag) begin
            output_wrap <= 1'b0;
        end
    end

endmodule
